// File: rtl/max_pool_2x2.sv
// 2x2, stride-2 max pooling over a raster pixel stream.
// Even rows leave per-pair maxima in a half-width row buffer; odd rows finish each window.
module max_pool_2x2 #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH   = 26,
  parameter int IN_HEIGHT  = 26
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int CW    = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 2;
  localparam int RW    = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
  localparam int BW    = CW - 1;
  localparam int DEPTH = IN_WIDTH / 2;

  localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] rowbuf [DEPTH];

  logic [BW-1:0]         buf_idx;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] rowbuf_rd;
  logic [DATA_WIDTH-1:0] win_max;
  logic                  last_col;
  logic                  last_row;

  // Column pairs map onto buffer entries, so the low col bit is dropped.
  assign buf_idx  = col[CW-1:1];
  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);

  always_comb begin
    pair_max  = (data_in > hold) ? data_in : hold;
    rowbuf_rd = rowbuf[buf_idx];
    win_max   = (rowbuf_rd > pair_max) ? rowbuf_rd : pair_max;
  end

  // Buffer is never reset: each entry is written on an even row before the odd row reads it.
  always_ff @(posedge Clk) begin
    if (!Rst && valid_in && !row[0] && col[0]) begin
      rowbuf[buf_idx] <= pair_max;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end

        if (!col[0]) begin
          hold <= data_in;
        end else if (row[0]) begin
          data_out   <= win_max;
          valid_out  <= 1'b1;
          frame_done <= last_row && last_col;
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2: a 4x4 instance for most scenarios and a 6x2
// instance for back-to-back frames; every expected value is written out by hand.
module tb_max_pool_2x2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       valid_in_a = 1'b0;
  logic [7:0] data_in_a  = '0;
  logic       valid_out_a;
  logic [7:0] data_out_a;
  logic       frame_done_a;

  logic       valid_in_b = 1'b0;
  logic [7:0] data_in_b  = '0;
  logic       valid_out_b;
  logic [7:0] data_out_b;
  logic       frame_done_b;

  int total = 0;
  int bad   = 0;

  int acc_a = 0, acc_b = 0;
  bit last_acc_a = 0, last_acc_b = 0;
  int hold_changes_a = 0;
  logic [7:0] prev_d_a = '0;

  typedef struct {
    int data;
    int fd;
    int pix;
    int prev;
  } pulse_t;

  pulse_t q_a[$];
  pulse_t q_b[$];

  max_pool_2x2 #(.DATA_WIDTH(8), .IN_WIDTH(4), .IN_HEIGHT(4)) dut_a (
    .Clk(clk), .Rst(rst), .valid_in(valid_in_a), .data_in(data_in_a),
    .valid_out(valid_out_a), .data_out(data_out_a), .frame_done(frame_done_a)
  );

  max_pool_2x2 #(.DATA_WIDTH(8), .IN_WIDTH(6), .IN_HEIGHT(2)) dut_b (
    .Clk(clk), .Rst(rst), .valid_in(valid_in_b), .data_in(data_in_b),
    .valid_out(valid_out_b), .data_out(data_out_b), .frame_done(frame_done_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Pulses are logged together with the index of the last accepted pixel and
  // whether the preceding edge accepted a pixel at all.
  always @(negedge clk) begin
    pulse_t p;
    if (valid_out_a === 1'b1) begin
      p.data = int'(data_out_a); p.fd = int'(frame_done_a);
      p.pix = acc_a - 1; p.prev = int'(last_acc_a);
      q_a.push_back(p);
    end else if (frame_done_a !== 1'b0) begin
      p.data = -1; p.fd = 1; p.pix = -1; p.prev = 0;
      q_a.push_back(p);
    end else if (data_out_a !== prev_d_a) begin
      hold_changes_a++;
    end
    prev_d_a = data_out_a;
    if (valid_out_b === 1'b1) begin
      p.data = int'(data_out_b); p.fd = int'(frame_done_b);
      p.pix = acc_b - 1; p.prev = int'(last_acc_b);
      q_b.push_back(p);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Caller is at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input bit sel, input logic [7:0] px, input bit v, input bit r);
    rst = r;
    if (sel) begin valid_in_b = v; data_in_b = px; end
    else     begin valid_in_a = v; data_in_a = px; end
    @(posedge clk);
    #1;
    if (sel) begin last_acc_b = v && !r; if (v && !r) acc_b++; end
    else     begin last_acc_a = v && !r; if (v && !r) acc_a++; end
    @(negedge clk);
  endtask

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) applyStimulus(sel, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic verifyPulses(input bit sel, input string tag, input int n,
                              input int ed[8], input int ep[8], input int ef[8]);
    pulse_t p;
    int sz;
    sz = sel ? q_b.size() : q_a.size();
    checkOutput({tag, " count"}, sz, n);
    for (int i = 0; i < n && i < sz; i++) begin
      p = sel ? q_b[i] : q_a[i];
      checkOutput($sformatf("%s data[%0d]", tag, i), p.data, ed[i]);
      checkOutput($sformatf("%s pix[%0d]", tag, i), p.pix, ep[i]);
      checkOutput($sformatf("%s fd[%0d]", tag, i), p.fd, ef[i]);
      checkOutput($sformatf("%s prev[%0d]", tag, i), p.prev, 1);
    end
    if (sel) q_b.delete(); else q_a.delete();
  endtask

  initial begin
    logic [7:0] f3a [16];
    logic [7:0] f3b [16];
    f3a = '{200, 10, 10, 201,  10, 10, 10, 10,  10, 10, 10, 10,  202, 10, 10, 203};
    f3b = '{0, 255, 128, 127,  0, 0, 1, 0,  7, 3, 0, 0,  2, 9, 0, 0};

    @(negedge clk);

    // Reset held with live pixels: nothing may come out.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'($urandom), 1'b1, 1'b1);
      checkOutput($sformatf("rst valid_out[%0d]", i), valid_out_a, 0);
      checkOutput($sformatf("rst frame_done[%0d]", i), frame_done_a, 0);
      checkOutput($sformatf("rst data_out[%0d]", i), data_out_a, 0);
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("post-rst valid_out", valid_out_a, 0);
    checkOutput("post-rst frame_done", frame_done_a, 0);
    checkOutput("post-rst data_out", data_out_a, 0);
    checkOutput("post-rst data_out_b", data_out_b, 0);
    q_a.delete(); q_b.delete();

    // Ascending frame: outputs follow pixels 5, 7, 13, 15.
    acc_a = 0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'(i), 1'b1, 1'b0);
    idle(1'b0, 2);
    verifyPulses(1'b0, "ramp", 4, '{5, 7, 13, 15, 0, 0, 0, 0},
                 '{5, 7, 13, 15, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0});

    // Max in each window corner, then an unsigned-compare frame.
    acc_a = 0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, f3a[i], 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, f3b[i], 1'b1, 1'b0);
    idle(1'b0, 2);
    verifyPulses(1'b0, "corners", 8, '{200, 201, 202, 203, 255, 128, 9, 0},
                 '{5, 7, 13, 15, 21, 23, 29, 31}, '{0, 0, 0, 1, 0, 0, 0, 1});

    // Ramp again with random gaps; held output must never move between pulses.
    acc_a = 0;
    hold_changes_a = 0;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) idle(1'b0, int'($urandom_range(1, 3)));
      applyStimulus(1'b0, 8'(i), 1'b1, 1'b0);
    end
    idle(1'b0, 3);
    verifyPulses(1'b0, "gappy", 4, '{5, 7, 13, 15, 0, 0, 0, 0},
                 '{5, 7, 13, 15, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0});
    checkOutput("gappy hold changes", hold_changes_a, 0);
    checkOutput("gappy final data_out", data_out_a, 15);

    // Partial frame aborted by reset; the pixel coinciding with reset is dropped.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'(100 + i), 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd105, 1'b1, 1'b1);
    checkOutput("abort valid_out", valid_out_a, 0);
    checkOutput("abort data_out", data_out_a, 0);
    checkOutput("abort pulses", q_a.size(), 0);
    acc_a = 0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'(i), 1'b1, 1'b0);
    idle(1'b0, 2);
    verifyPulses(1'b0, "restart", 4, '{5, 7, 13, 15, 0, 0, 0, 0},
                 '{5, 7, 13, 15, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0});

    // 6x2 instance: back-to-back frames, ascending then descending.
    acc_b = 0;
    q_b.delete();
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 11; i >= 0; i--) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
    idle(1'b1, 2);
    verifyPulses(1'b1, "b2b", 6, '{7, 9, 11, 11, 9, 7, 0, 0},
                 '{7, 9, 11, 19, 21, 23, 0, 0}, '{0, 0, 1, 0, 0, 1, 0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
